// File: rtl/quadrature_emitter_pkg.sv
// Shared rotary-encoder definitions: FSM state encodings, A/B patterns, direction constants.
// The decoder side imports the same package so both ends agree on the waveform.
package quadrature_emitter_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PH1  = 3'd1;
  localparam logic [2:0] ST_PH2  = 3'd2;
  localparam logic [2:0] ST_PH3  = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // {A,B} patterns; up detents pull A low first, down detents pull B low first
  localparam logic [1:0] AB_IDLE   = 2'b11;
  localparam logic [1:0] AB_MID    = 2'b00;
  localparam logic [1:0] AB_UP_PH1 = 2'b01;
  localparam logic [1:0] AB_UP_PH3 = 2'b10;
  localparam logic [1:0] AB_DN_PH1 = 2'b10;
  localparam logic [1:0] AB_DN_PH3 = 2'b01;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/quadrature_emitter_if.sv
// Request/response bundle of the quadrature emitter: step/press requests in,
// encoder waveforms and queue status out.
interface quadrature_emitter_if;
  logic              step_up;
  logic              step_down;
  logic              press;
  logic              out_a;
  logic              out_b;
  logic              out_sw_n;
  logic              busy;
  logic signed [7:0] pending;
  logic              dropped;

  modport master (
    output step_up, step_down, press,
    input  out_a, out_b, out_sw_n, busy, pending, dropped
  );

  modport slave (
    input  step_up, step_down, press,
    output out_a, out_b, out_sw_n, busy, pending, dropped
  );
endinterface

// File: rtl/quadrature_emitter_phase_timer.sv
// Loadable down-counter that stops at zero; done is high while the count is zero.
module quadrature_emitter_phase_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_value;
    end else if (count && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/quadrature_emitter.sv
// Rotary-encoder waveform generator: turns queued step requests into quadrature
// detents and press requests into fixed-length active-low switch pulses.
module quadrature_emitter
  import quadrature_emitter_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 1000,
  parameter int unsigned GAP_CYCLES   = 4000,
  parameter int unsigned BTN_CYCLES   = 50000,
  parameter int unsigned MAX_PENDING  = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  quadrature_emitter_if.slave  bus
);

  localparam int unsigned TW = $clog2(max3(PHASE_CYCLES, GAP_CYCLES, BTN_CYCLES) + 1);
  localparam logic signed [8:0] MAXP = 9'(MAX_PENDING);

  logic [2:0]        state_q;
  logic              dir_q;
  logic [1:0]        ab_q;
  logic signed [7:0] pending_q;
  logic              dropped_q;
  logic              sw_low_q;

  logic              start, dir_new;
  logic              ph_load, ph_count, ph_done;
  logic [TW-1:0]     ph_value;
  logic              press_accept, sw_done;
  logic signed [8:0] pend_ext, req_delta, take, sum;
  logic              overflow;

  assign start   = (state_q == ST_IDLE) && (pending_q != '0);
  assign dir_new = pending_q[7] ? DIR_DOWN : DIR_UP;

  // New requests and the step taken by a starting detent are summed before the
  // saturation check, so a full queue can still accept a request while draining.
  always_comb begin
    req_delta = '0;
    if (bus.step_up && !bus.step_down) req_delta = 9'sd1;
    else if (!bus.step_up && bus.step_down) req_delta = -9'sd1;
    take = '0;
    if (start) take = pending_q[7] ? 9'sd1 : -9'sd1;
    pend_ext = {pending_q[7], pending_q};
    sum      = pend_ext + req_delta + take;
    overflow = (sum > MAXP) || (sum < -MAXP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      dropped_q <= 1'b0;
    end else begin
      dropped_q <= overflow;
      if (!overflow) pending_q <= sum[7:0];
    end
  end

  assign ph_load  = start || ((state_q != ST_IDLE) && (state_q != ST_GAP) && ph_done);
  assign ph_value = (state_q == ST_PH3) ? TW'(GAP_CYCLES - 1) : TW'(PHASE_CYCLES - 1);
  assign ph_count = (state_q != ST_IDLE);

  quadrature_emitter_phase_timer #(.WIDTH(TW)) u_phase_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ph_load),
    .load_value (ph_value),
    .count      (ph_count),
    .done       (ph_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      ab_q    <= AB_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          state_q <= ST_PH1;
          dir_q   <= dir_new;
          ab_q    <= (dir_new == DIR_UP) ? AB_UP_PH1 : AB_DN_PH1;
        end
        ST_PH1: if (ph_done) begin
          state_q <= ST_PH2;
          ab_q    <= AB_MID;
        end
        ST_PH2: if (ph_done) begin
          state_q <= ST_PH3;
          ab_q    <= (dir_q == DIR_UP) ? AB_UP_PH3 : AB_DN_PH3;
        end
        ST_PH3: if (ph_done) begin
          state_q <= ST_GAP;
          ab_q    <= AB_IDLE;
        end
        ST_GAP: if (ph_done) state_q <= ST_IDLE;
        default: begin
          state_q <= ST_IDLE;
          ab_q    <= AB_IDLE;
        end
      endcase
    end
  end

  assign press_accept = bus.press && !sw_low_q;

  quadrature_emitter_phase_timer #(.WIDTH(TW)) u_switch_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (press_accept),
    .load_value (TW'(BTN_CYCLES - 1)),
    .count      (sw_low_q),
    .done       (sw_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_low_q <= 1'b0;
    end else if (press_accept) begin
      sw_low_q <= 1'b1;
    end else if (sw_low_q && sw_done) begin
      sw_low_q <= 1'b0;
    end
  end

  assign bus.out_a    = ab_q[1];
  assign bus.out_b    = ab_q[0];
  assign bus.out_sw_n = ~sw_low_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.pending  = pending_q;
  assign bus.dropped  = dropped_q;

endmodule

// File: tb/tb_quadrature_emitter.sv
// Bench for quadrature_emitter: offset-based behavioural model checked every cycle,
// plus directed scenarios with hand-computed cycle-exact expectations.
module tb_quadrature_emitter;

  localparam int P      = 4;
  localparam int G      = 8;
  localparam int B      = 6;
  localparam int MAXP   = 3;
  localparam int DETENT = 3 * P + G;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  quadrature_emitter_if bus();

  quadrature_emitter #(
    .PHASE_CYCLES (P),
    .GAP_CYCLES   (G),
    .BTN_CYCLES   (B),
    .MAX_PENDING  (MAXP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ab_now();
    return {bus.out_a, bus.out_b};
  endfunction

  // Model: a detent is a window of DETENT cycles measured from its first PH1 cycle.
  int m_pend, m_off, m_sw_left;
  bit m_active, m_dir, m_drop;

  always @(posedge clk or negedge rst_n) begin
    int req, take, sum;
    if (!rst_n) begin
      m_pend = 0; m_off = 0; m_sw_left = 0;
      m_active = 0; m_dir = 0; m_drop = 0;
    end else begin
      req  = (bus.step_up && !bus.step_down) ? 1 : ((!bus.step_up && bus.step_down) ? -1 : 0);
      take = 0;
      if (m_active) begin
        m_off++;
        if (m_off == DETENT) m_active = 0;
      end else if (m_pend != 0) begin
        m_active = 1; m_off = 0; m_dir = (m_pend > 0);
        take = (m_pend > 0) ? -1 : 1;
      end
      sum    = m_pend + req + take;
      m_drop = (sum > MAXP) || (sum < -MAXP);
      if (!m_drop) m_pend = sum;
      if (m_sw_left > 0) m_sw_left--;
      else if (bus.press) m_sw_left = B;
    end
  end

  function automatic logic [1:0] exp_ab();
    if (!m_active)     return 2'b11;
    if (m_off < P)     return m_dir ? 2'b01 : 2'b10;
    if (m_off < 2 * P) return 2'b00;
    if (m_off < 3 * P) return m_dir ? 2'b10 : 2'b01;
    return 2'b11;
  endfunction

  logic [1:0] prev_ab = 2'b11;
  int up_det = 0, down_det = 0, drop_seen = 0;

  always @(negedge clk) begin
    logic [1:0] ab;
    ab = ab_now();
    if (rst_n) begin
      chk("model_ab",      ab, exp_ab());
      chk("model_busy",    bus.busy, m_active);
      chk("model_pending", $signed(bus.pending), m_pend);
      chk("model_dropped", bus.dropped, m_drop);
      chk("model_sw_n",    bus.out_sw_n, (m_sw_left == 0));
      if (ab != prev_ab) chk("gray_step", $countones(ab ^ prev_ab), 1);
      if (ab == 2'b11 && prev_ab == 2'b10) up_det++;
      if (ab == 2'b11 && prev_ab == 2'b01) down_det++;
      if (bus.dropped) drop_seen++;
    end
    prev_ab = ab;
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((bus.busy || bus.pending != 0) && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, (bus.busy || bus.pending != 0), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int u0, d0, dr0;
    bus.step_up = 1'b0; bus.step_down = 1'b0; bus.press = 1'b0;
    tick(3);
    rst_n = 1'b1;

    chk("rst_ab", ab_now(), 2'b11);
    chk("rst_sw_n", bus.out_sw_n, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pending", $signed(bus.pending), 0);
    chk("rst_dropped", bus.dropped, 0);

    // Single up detent, cycle-exact
    u0 = up_det;
    bus.step_up = 1'b1; tick(1); bus.step_up = 1'b0;
    chk("up_pend_n1", $signed(bus.pending), 1);
    chk("up_ab_n1", ab_now(), 2'b11);
    tick(1);
    chk("up_ab_n2", ab_now(), 2'b01);
    chk("up_busy_n2", bus.busy, 1);
    chk("up_pend_n2", $signed(bus.pending), 0);
    tick(3);  chk("up_ab_n5", ab_now(), 2'b01);
    tick(1);  chk("up_ab_n6", ab_now(), 2'b00);
    tick(4);  chk("up_ab_n10", ab_now(), 2'b10);
    tick(4);  chk("up_ab_n14", ab_now(), 2'b11);
    chk("up_busy_n14", bus.busy, 1);
    tick(7);  chk("up_busy_n21", bus.busy, 1);
    tick(1);  chk("up_busy_n22", bus.busy, 0);
    chk("up_count", up_det - u0, 1);

    // Two back-to-back down requests
    u0 = up_det; d0 = down_det;
    bus.step_down = 1'b1; tick(2); bus.step_down = 1'b0;
    chk("dn_pend_n2", $signed(bus.pending), -1);
    chk("dn_ab_n2", ab_now(), 2'b10);
    tick(20);
    chk("dn_busy_n22", bus.busy, 0);
    chk("dn_ab_n22", ab_now(), 2'b11);
    chk("dn_pend_n22", $signed(bus.pending), -1);
    tick(1);
    chk("dn_ab_n23", ab_now(), 2'b10);
    chk("dn_busy_n23", bus.busy, 1);
    chk("dn_pend_n23", $signed(bus.pending), 0);
    wait_idle("dn_idle", 200);
    chk("dn_down_count", down_det - d0, 2);
    chk("dn_up_count", up_det - u0, 0);

    // Saturation: five ups during a detent
    u0 = up_det; dr0 = drop_seen;
    bus.step_up = 1'b1; tick(1); bus.step_up = 1'b0; tick(3);
    bus.step_up = 1'b1; tick(5); bus.step_up = 1'b0;
    chk("sat_pending", $signed(bus.pending), 3);
    chk("sat_dropped_on", bus.dropped, 1);
    tick(1);
    chk("sat_dropped_off", bus.dropped, 0);
    chk("sat_drop_count", drop_seen - dr0, 2);
    wait_idle("sat_idle", 300);
    chk("sat_detents", up_det - u0, 4);

    // Simultaneous up/down, then cancellation of queued steps
    u0 = up_det; dr0 = drop_seen;
    bus.step_up = 1'b1; tick(1); bus.step_up = 1'b0; tick(3);
    bus.step_up = 1'b1; tick(2); bus.step_up = 1'b0;
    chk("cx_pend_2", $signed(bus.pending), 2);
    bus.step_up = 1'b1; bus.step_down = 1'b1; tick(1);
    bus.step_up = 1'b0; bus.step_down = 1'b0;
    chk("cx_pend_same", $signed(bus.pending), 2);
    chk("cx_no_drop", bus.dropped, 0);
    bus.step_down = 1'b1; tick(2); bus.step_down = 1'b0;
    chk("cx_pend_0", $signed(bus.pending), 0);
    chk("cx_busy", bus.busy, 1);
    wait_idle("cx_idle", 100);
    chk("cx_detents", up_det - u0, 1);
    chk("cx_drops", drop_seen - dr0, 0);

    // Press with concurrent detent; re-press while low is ignored
    u0 = up_det;
    bus.press = 1'b1; bus.step_up = 1'b1; tick(1);
    bus.press = 1'b0; bus.step_up = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      chk($sformatf("sw_n_%0d", k), bus.out_sw_n, (k <= B) ? 0 : 1);
      bus.press = (k == 3);
      tick(1);
    end
    bus.press = 1'b0;
    wait_idle("sw_idle", 100);
    chk("sw_detent", up_det - u0, 1);

    // Asynchronous reset in the middle of PH2 with a queued step and switch held
    bus.step_up = 1'b1; tick(2); bus.step_up = 1'b0;
    tick(3);
    bus.press = 1'b1; tick(1); bus.press = 1'b0;
    tick(1);
    chk("ar_pre_ab", ab_now(), 2'b00);
    chk("ar_pre_sw", bus.out_sw_n, 0);
    chk("ar_pre_pend", $signed(bus.pending), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ab", ab_now(), 2'b11);
    chk("ar_sw_n", bus.out_sw_n, 1);
    chk("ar_busy", bus.busy, 0);
    chk("ar_pending", $signed(bus.pending), 0);
    chk("ar_dropped", bus.dropped, 0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    chk("ar_post_busy", bus.busy, 0);
    chk("ar_post_ab", ab_now(), 2'b11);

    // Sparse random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus.step_up   = ($urandom_range(0, 7) == 0);
      bus.step_down = ($urandom_range(0, 9) == 0);
      bus.press     = ($urandom_range(0, 15) == 0);
      tick(1);
    end
    bus.step_up = 1'b0; bus.step_down = 1'b0; bus.press = 1'b0;
    wait_idle("rnd_idle", 300);
    tick(B + 2);
    chk("rnd_sw_released", bus.out_sw_n, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
